// File: rtl/fb_draw_writer.sv
// fb_draw_writer: clears a framebuffer, then streams clipped pixels from a drawing stage into it.
// Optional clear phase: define FB_DRAW_WRITER_CLEAR_EN to build it in.
module fb_draw_writer #(
  parameter int CORDW     = 16,
  parameter int CIDXW     = 4,
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 180,
  parameter int FB_ADDRW  = 16,
  parameter int BG_CIDX   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  output logic                    render_start,
  output logic                    render_oe,
  input  logic signed [CORDW-1:0] px_x,
  input  logic signed [CORDW-1:0] px_y,
  input  logic [CIDXW-1:0]        px_cidx,
  input  logic                    px_drawing,
  input  logic                    render_done,
  output logic                    fb_we,
  output logic [FB_ADDRW-1:0]     fb_addr,
  output logic [CIDXW-1:0]        fb_cidx,
  output logic                    busy,
  output logic                    done
);

  localparam int MW = CORDW + FB_ADDRW;

  // Elaboration-time parameter sanity checks.
  if ((BG_CIDX < 0) || (BG_CIDX >= (1 << CIDXW))) begin : g_bg_range
    $error("BG_CIDX does not fit in CIDXW bits");
  end
  if ((longint'(FB_WIDTH) * longint'(FB_HEIGHT)) > (longint'(1) << FB_ADDRW)) begin : g_addr_range
    $error("FB_ADDRW too small for FB_WIDTH*FB_HEIGHT");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RSTART = 3'd2,
    RENDER = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state_r, state_s;
  logic   drain_cnt_r;

  logic                    s1_vld_r;
  logic signed [CORDW-1:0] s1_x_r, s1_y_r;
  logic [CIDXW-1:0]        s1_cidx_r;
  logic                    accept_s, inb_s;

  logic                    we_r;
  logic [FB_ADDRW-1:0]     addr_r, addr_s;
  logic [CIDXW-1:0]        cidx_r;

`ifdef FB_DRAW_WRITER_CLEAR_EN
  localparam logic [FB_ADDRW-1:0] CLR_LAST = FB_ADDRW'(FB_WIDTH * FB_HEIGHT - 1);
  logic [FB_ADDRW-1:0] clr_cnt_r;
  logic                clr_last_s;
  assign clr_last_s = (clr_cnt_r == CLR_LAST);
`endif

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_start) begin
`ifdef FB_DRAW_WRITER_CLEAR_EN
          state_s = CLEAR;
`else
          state_s = RSTART;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
`ifdef FB_DRAW_WRITER_CLEAR_EN
        if (clr_last_s) begin
          state_s = RSTART;
        end else begin
          state_s = CLEAR;
        end
`else
        state_s = IDLE;
`endif
      end
      RSTART: state_s = RENDER;
      RENDER: begin
        if (render_done) begin
          state_s = DRAIN;
        end else begin
          state_s = RENDER;
        end
      end
      DRAIN: begin
        if (drain_cnt_r) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and two-cycle drain timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      drain_cnt_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      drain_cnt_r <= (state_r == DRAIN) ? ~drain_cnt_r : 1'b0;
    end
  end

`ifdef FB_DRAW_WRITER_CLEAR_EN
  // Clear address counter, walks 0..W*H-1 while in CLEAR.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt_r <= '0;
    end else if ((state_r == CLEAR) && !clr_last_s) begin
      clr_cnt_r <= clr_cnt_r + FB_ADDRW'(1);
    end else begin
      clr_cnt_r <= '0;
    end
  end
`endif

  // Signed bounds test; pixels outside the framebuffer are dropped here.
  assign accept_s = (state_r == RENDER) && px_drawing;
  assign inb_s    = (int'(px_x) >= 0) && (int'(px_x) < FB_WIDTH) &&
                    (int'(px_y) >= 0) && (int'(px_y) < FB_HEIGHT);

  // Pipeline stage 1: capture coordinates and the in-bounds valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_r  <= 1'b0;
      s1_x_r    <= '0;
      s1_y_r    <= '0;
      s1_cidx_r <= '0;
    end else begin
      s1_vld_r  <= accept_s && inb_s;
      s1_x_r    <= px_x;
      s1_y_r    <= px_y;
      s1_cidx_r <= px_cidx;
    end
  end

  // Coordinates are known non-negative once valid, so unsigned math is safe.
  assign addr_s = FB_ADDRW'(MW'($unsigned(s1_y_r)) * MW'(FB_WIDTH) + MW'($unsigned(s1_x_r)));

  // Pipeline stage 2: address, data and write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r   <= 1'b0;
      addr_r <= '0;
      cidx_r <= '0;
    end else begin
      we_r <= s1_vld_r;
      if (s1_vld_r) begin
        addr_r <= addr_s;
        cidx_r <= s1_cidx_r;
      end else begin
        addr_r <= addr_r;
        cidx_r <= cidx_r;
      end
    end
  end

`ifdef FB_DRAW_WRITER_CLEAR_EN
  // Clear writes own the port in CLEAR; the pipeline is empty there.
  always_comb begin
    if (state_r == CLEAR) begin
      fb_we   = 1'b1;
      fb_addr = clr_cnt_r;
      fb_cidx = CIDXW'(BG_CIDX);
    end else begin
      fb_we   = we_r;
      fb_addr = addr_r;
      fb_cidx = cidx_r;
    end
  end
`else
  assign fb_we   = we_r;
  assign fb_addr = addr_r;
  assign fb_cidx = cidx_r;
`endif

  assign render_start = (state_r == RSTART);
  assign render_oe    = (state_r == RENDER);
  assign busy         = (state_r != IDLE);
  assign done         = (state_r == DONE);

endmodule

// File: tb/tb_fb_draw_writer.sv
// Randomized bench for fb_draw_writer: a cycle-tagged write scoreboard plus a per-cycle
// control expectation, both derived from the frame protocol, checked on every falling edge.
module tb_fb_draw_writer;
  localparam int W = 320;
  localparam int H = 180;
`ifdef FB_DRAW_WRITER_CLEAR_EN
  localparam int NCLR = W * H;
`else
  localparam int NCLR = 0;
`endif
  // {busy, render_oe, render_start, done}
  localparam logic [3:0] C_IDLE  = 4'b0000;
  localparam logic [3:0] C_BUSY  = 4'b1000;
  localparam logic [3:0] C_OE    = 4'b1100;
  localparam logic [3:0] C_START = 4'b1010;
  localparam logic [3:0] C_DONE  = 4'b1001;

  logic clk = 1'b0;
  logic rst, frame_start, render_start, render_oe, px_drawing, render_done;
  logic fb_we, busy, done;
  logic signed [15:0] px_x, px_y;
  logic [3:0]  px_cidx, fb_cidx;
  logic [15:0] fb_addr;

  fb_draw_writer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .render_start(render_start),
    .render_oe(render_oe), .px_x(px_x), .px_y(px_y), .px_cidx(px_cidx),
    .px_drawing(px_drawing), .render_done(render_done), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_cidx(fb_cidx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int addr; int cidx; } wr_t;
  wr_t wq[$];
  wr_t lq[$];
  logic [3:0] exp_ctl = 4'b0000;
  bit chk_en = 1'b0, rst_chk = 1'b0, end_chk = 1'b0;
  int checks = 0, errors = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({busy, render_oe, render_start, done} !== exp_ctl) begin
        errors++;
        $display("FAIL ctl cyc=%0d got=%b exp=%b", cyc, {busy, render_oe, render_start, done}, exp_ctl);
      end
      while (wq.size() > 0 && wq[0].c < cyc) begin
        checks++; errors++;
        $display("FAIL missed_write cyc=%0d exp_addr=%0d", wq[0].c, wq[0].addr);
        wq.delete(0);
      end
      checks++;
      if (wq.size() > 0 && wq[0].c == cyc) begin
        if (fb_we !== 1'b1 || fb_addr !== 16'(wq[0].addr) || fb_cidx !== 4'(wq[0].cidx))
          begin
            errors++;
            $display("FAIL write cyc=%0d got we=%b addr=%0d cidx=%0d exp addr=%0d cidx=%0d",
                     cyc, fb_we, fb_addr, fb_cidx, wq[0].addr, wq[0].cidx);
          end
        wq.delete(0);
      end else if (fb_we !== 1'b0) begin
        errors++;
        $display("FAIL spurious_write cyc=%0d got we=%b addr=%0d exp we=0", cyc, fb_we, fb_addr);
      end
      if (lq.size() > 0 && lq[0].c == cyc) begin
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== 16'(lq[0].addr) || fb_cidx !== 4'(lq[0].cidx)) begin
          errors++;
          $display("FAIL literal cyc=%0d got addr=%0d cidx=%0d exp addr=%0d cidx=%0d",
                   cyc, fb_addr, fb_cidx, lq[0].addr, lq[0].cidx);
        end
        lq.delete(0);
      end
      if (rst_chk) begin
        checks++;
        if (fb_addr !== 16'd0 || fb_cidx !== 4'd0 || fb_we !== 1'b0) begin
          errors++;
          $display("FAIL reset_out cyc=%0d got we=%b addr=%0d cidx=%0d exp 0", cyc, fb_we, fb_addr, fb_cidx);
        end
      end
    end
    if (end_chk) begin
      checks++;
      if (wq.size() != 0 || lq.size() != 0) begin
        errors++;
        $display("FAIL leftover got=%0d/%0d pending exp=0", wq.size(), lq.size());
      end
    end
  end

  function automatic bit inb(int x, int y);
    return (x >= 0) && (x < W) && (y >= 0) && (y < H);
  endfunction

  task automatic go(input logic [3:0] ctl);
    exp_ctl = ctl;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    frame_start = 1'b0; px_drawing = 1'b0; render_done = 1'b0;
  endtask

  task automatic noise(input bit fs);
    px_drawing  = 1'($urandom_range(0, 1));
    px_x        = 16'($urandom_range(0, 300));
    px_y        = 16'($urandom_range(0, 170));
    px_cidx     = 4'($urandom_range(0, 15));
    frame_start = fs && ($urandom_range(0, 7) == 0);
    render_done = 1'b0;
  endtask

  // One render cycle; a drawn in-bounds pixel must appear two cycles later.
  task automatic drive_px(input int x, input int y, input int c, input bit dr, input bit last,
                          input int lit);
    px_x = 16'(x); px_y = 16'(y); px_cidx = 4'(c);
    px_drawing = dr; render_done = last;
    frame_start = ($urandom_range(0, 9) == 0);
    if (dr && inb(x, y)) wq.push_back('{cyc + 2, y * W + x, c});
    if (lit >= 0) lq.push_back('{cyc + 2, lit, c});
    go(C_OE);
  endtask

  task automatic start_frame();
    int s;
    quiet();
    frame_start = 1'b1;
    go(C_IDLE);
    s = cyc;
    for (int i = 0; i < NCLR; i++) wq.push_back('{s + i, i, 0});
`ifdef FB_DRAW_WRITER_CLEAR_EN
    lq.push_back('{s, 0, 0});
    lq.push_back('{s + NCLR - 1, 57599, 0});
`endif
    for (int i = 0; i < NCLR; i++) begin
      noise(1'b1);
      go(C_BUSY);
    end
    noise(1'b1);
    go(C_START);
  endtask

  task automatic end_frame();
    noise(1'b1); go(C_BUSY);
    noise(1'b1); go(C_BUSY);
    noise(1'b1); go(C_DONE);
    quiet();     go(C_IDLE);
    go(C_IDLE);
  endtask

  task automatic directed_frame();
    start_frame();
    drive_px(130, 60, 3, 1'b1, 1'b0, 19330);
    drive_px(-1, 10, 1, 1'b1, 1'b0, -1);
    drive_px(320, 0, 2, 1'b1, 1'b0, -1);
    drive_px(5, 180, 4, 1'b1, 1'b0, -1);
    drive_px(0, -5, 6, 1'b1, 1'b0, -1);
    drive_px(0, 0, 5, 1'b1, 1'b0, 0);
    drive_px(100, 100, 8, 1'b0, 1'b0, -1);
    drive_px(319, 179, 7, 1'b1, 1'b0, 57599);
    drive_px(229, 159, 9, 1'b1, 1'b1, 51109);
    end_frame();
  endtask

  // Random pixels; abort_at >= 0 asserts rst at that pixel instead of finishing.
  task automatic rand_frame(input int n, input int abort_at);
    int x, y;
    start_frame();
    for (int j = 0; j < n; j++) begin
      if (j == abort_at) begin
        rst = 1'b1; px_drawing = 1'b1; frame_start = 1'b0;
        while (wq.size() > 0 && wq[wq.size() - 1].c > cyc) wq.delete(wq.size() - 1);
        go(C_OE);
        rst = 1'b0; quiet();
        rst_chk = 1'b1; go(C_IDLE); rst_chk = 1'b0;
        go(C_IDLE);
        return;
      end
      x = int'($urandom_range(0, 360)) - 20;
      y = int'($urandom_range(0, 220)) - 20;
      drive_px(x, y, int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), (j == n - 1), -1);
    end
    end_frame();
  endtask

`ifdef FB_DRAW_WRITER_CLEAR_EN
  task automatic abort_clear();
    int s;
    quiet();
    frame_start = 1'b1;
    go(C_IDLE);
    s = cyc;
    for (int i = 0; i < 100; i++) wq.push_back('{s + i, i, 0});
    lq.push_back('{s, 0, 0});
    for (int i = 0; i < 99; i++) begin
      noise(1'b1);
      go(C_BUSY);
    end
    rst = 1'b1;
    go(C_BUSY);
    rst = 1'b0; quiet();
    rst_chk = 1'b1; go(C_IDLE); rst_chk = 1'b0;
    go(C_IDLE);
  endtask
`endif

  initial begin
    rst = 1'b1; px_x = '0; px_y = '0; px_cidx = '0;
    quiet();
    @(posedge clk); #1;
    chk_en = 1'b1; rst_chk = 1'b1;
    go(C_IDLE); go(C_IDLE);
    rst = 1'b0;
    go(C_IDLE);
    rst_chk = 1'b0;
    go(C_IDLE);
`ifdef FB_DRAW_WRITER_CLEAR_EN
    abort_clear();
    directed_frame();
`else
    directed_frame();
    for (int f = 0; f < 3; f++) rand_frame(150, -1);
    rand_frame(60, 37);
    rand_frame(80, -1);
`endif
    go(C_IDLE);
    end_chk = 1'b1;
    @(negedge clk);
    #1;
    end_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
